// File: rtl/score_keeper_bcd.sv
// Multi-player BCD score keeper for Pong: per-player ripple-carry BCD counters,
// saturate/wrap at all-9s, overflow strobes and a PLAY/OVER win FSM.
module score_keeper_bcd #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter bit WRAP_MODE   = 1'b0,
  localparam int WID        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PLAYERS-1:0]        inc,
  input  logic                          clr,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score,
  output logic [NUM_PLAYERS-1:0]        ovf,
  output logic                          game_over,
  output logic [WID-1:0]                winner_id
);

  localparam int SW = DIGITS * 4;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  function automatic logic [SW-1:0] to_bcd(input int value);
    logic [SW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  function automatic logic is_all9(input logic [SW-1:0] s);
    logic all9;
    all9 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[k*4 +: 4] != 4'd9) all9 = 1'b0;
    end
    return all9;
  endfunction

  // Ripple carry: a digit at 9 takes the carry, becomes 0 and passes it on.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          carry;
    r     = s;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (s[k*4 +: 4] == 4'd9) begin
          r[k*4 +: 4] = 4'd0;
        end else begin
          r[k*4 +: 4] = s[k*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Terminal-count policy at all-9s: hold, or roll over to zero.
  function automatic logic [SW-1:0] sat_or_wrap(input logic [SW-1:0] s);
    return WRAP_MODE ? '0 : s;
  endfunction

  state_t                           state_p0, state_d;
  logic [NUM_PLAYERS*SW-1:0]        score_p0, score_d;
  logic [NUM_PLAYERS-1:0]           ovf_p0, ovf_d;
  logic [WID-1:0]                   winner_p0, winner_d;

  always_comb begin
    state_d  = state_p0;
    score_d  = score_p0;
    ovf_d    = '0;
    winner_d = winner_p0;
    if (clr) begin
      score_d  = '0;
      winner_d = '0;
      state_d  = PLAY;
    end else if (state_p0 == PLAY) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (inc[p]) begin
          if (is_all9(score_p0[p*SW +: SW])) begin
            score_d[p*SW +: SW] = sat_or_wrap(score_p0[p*SW +: SW]);
            ovf_d[p]            = 1'b1;
          end else begin
            score_d[p*SW +: SW] = bcd_inc(score_p0[p*SW +: SW]);
          end
        end
      end
      // Descending scan so the lowest matching index is the one that sticks.
      if (WIN_SCORE != 0) begin
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
          if (score_d[p*SW +: SW] == WIN_BCD) begin
            winner_d = WID'(p);
            state_d  = OVER;
          end
        end
      end
    end
  end

  // ---- stage p0: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= PLAY;
      score_p0  <= '0;
      ovf_p0    <= '0;
      winner_p0 <= '0;
    end else begin
      state_p0  <= state_d;
      score_p0  <= score_d;
      ovf_p0    <= ovf_d;
      winner_p0 <= winner_d;
    end
  end

  assign score     = score_p0;
  assign ovf       = ovf_p0;
  assign game_over = (state_p0 == OVER);
  assign winner_id = winner_p0;

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Directed bench for score_keeper_bcd: four configurations (default, saturate,
// wrap, 4-player/3-digit) driven by per-scenario tasks with inline checks.
module tb_score_keeper_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // default config: 2 players, 2 digits, win at 11, saturate
  logic        rst_a, clr_a, go_a;
  logic [1:0]  inc_a, ovf_a;
  logic [15:0] score_a;
  logic [0:0]  wid_a;
  // no win detection, saturate
  logic        rst_b, clr_b, go_b;
  logic [1:0]  inc_b, ovf_b;
  logic [15:0] score_b;
  logic [0:0]  wid_b;
  // no win detection, wrap
  logic        rst_c, clr_c, go_c;
  logic [1:0]  inc_c, ovf_c;
  logic [15:0] score_c;
  logic [0:0]  wid_c;
  // 4 players, 3 digits, win at 250
  logic        rst_d, clr_d, go_d;
  logic [3:0]  inc_d, ovf_d;
  logic [47:0] score_d;
  logic [1:0]  wid_d;

  score_keeper_bcd #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .WRAP_MODE(1'b0)) u_def (
    .clk(clk), .reset(rst_a), .inc(inc_a), .clr(clr_a),
    .score(score_a), .ovf(ovf_a), .game_over(go_a), .winner_id(wid_a));
  score_keeper_bcd #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .WRAP_MODE(1'b0)) u_sat (
    .clk(clk), .reset(rst_b), .inc(inc_b), .clr(clr_b),
    .score(score_b), .ovf(ovf_b), .game_over(go_b), .winner_id(wid_b));
  score_keeper_bcd #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .WRAP_MODE(1'b1)) u_wrap (
    .clk(clk), .reset(rst_c), .inc(inc_c), .clr(clr_c),
    .score(score_c), .ovf(ovf_c), .game_over(go_c), .winner_id(wid_c));
  score_keeper_bcd #(.NUM_PLAYERS(4), .DIGITS(3), .WIN_SCORE(250), .WRAP_MODE(1'b0)) u_big (
    .clk(clk), .reset(rst_d), .inc(inc_d), .clr(clr_d),
    .score(score_d), .ovf(ovf_d), .game_over(go_d), .winner_id(wid_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
    inc_a = 2'b11; inc_b = 2'b11; inc_c = 2'b11; inc_d = 4'hf;
    clr_a = 0; clr_b = 0; clr_c = 0; clr_d = 0;
    tick(); tick();
    inc_a = 0; inc_b = 0; inc_c = 0; inc_d = 0;
    vectors++;
    if ({score_a, ovf_a, go_a, wid_a} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_def got %h expected 0", {score_a, ovf_a, go_a, wid_a});
    end
    vectors++;
    if ({score_b, ovf_b, go_b, score_c, ovf_c, go_c} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_satwrap got %h expected 0", {score_b, ovf_b, go_b, score_c, ovf_c, go_c});
    end
    vectors++;
    if ({score_d, ovf_d, go_d, wid_d} !== 55'h0) begin
      miscompares++;
      $display("FAIL reset_big got %h expected 0", {score_d, ovf_d, go_d, wid_d});
    end
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    tick();
  endtask

  task automatic test_win();
    for (int i = 0; i < 10; i++) begin
      inc_a = 2'b01; tick();
      inc_a = 2'b00; tick();
    end
    vectors++;
    if ({score_a, go_a} !== {16'h0010, 1'b0}) begin
      miscompares++;
      $display("FAIL win_pre got score=%h go=%b expected 0010 0", score_a, go_a);
    end
    inc_a = 2'b01; tick();
    inc_a = 2'b00;
    vectors++;
    if ({score_a, go_a, wid_a} !== {16'h0011, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL win_hit got score=%h go=%b wid=%0d expected 0011 1 0", score_a, go_a, wid_a);
    end
    inc_a = 2'b10; tick(); tick();
    inc_a = 2'b00;
    vectors++;
    if ({score_a, ovf_a, go_a} !== {16'h0011, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL over_hold got score=%h ovf=%b go=%b expected 0011 00 1", score_a, ovf_a, go_a);
    end
    clr_a = 1; tick(); clr_a = 0;
  endtask

  task automatic test_carry();
    inc_a = 2'b10;
    for (int i = 0; i < 9; i++) tick();
    vectors++;
    if (score_a !== 16'h0900) begin
      miscompares++;
      $display("FAIL carry_pre got %h expected 0900", score_a);
    end
    tick();
    inc_a = 2'b00;
    vectors++;
    if ({score_a, ovf_a, go_a} !== {16'h1000, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL carry_ripple got score=%h ovf=%b go=%b expected 1000 00 0", score_a, ovf_a, go_a);
    end
    clr_a = 1; tick(); clr_a = 0;
  endtask

  task automatic test_saturate();
    inc_b = 2'b01;
    for (int i = 0; i < 99; i++) tick();
    vectors++;
    if ({score_b, ovf_b} !== {16'h0099, 2'b00}) begin
      miscompares++;
      $display("FAIL sat_pre got score=%h ovf=%b expected 0099 00", score_b, ovf_b);
    end
    tick();
    inc_b = 2'b00;
    vectors++;
    if ({score_b, ovf_b, go_b} !== {16'h0099, 2'b01, 1'b0}) begin
      miscompares++;
      $display("FAIL sat_ovf got score=%h ovf=%b go=%b expected 0099 01 0", score_b, ovf_b, go_b);
    end
    tick();
    vectors++;
    if ({score_b, ovf_b} !== {16'h0099, 2'b00}) begin
      miscompares++;
      $display("FAIL sat_ovf_end got score=%h ovf=%b expected 0099 00", score_b, ovf_b);
    end
  endtask

  task automatic test_wrap();
    inc_c = 2'b01;
    for (int i = 0; i < 99; i++) tick();
    vectors++;
    if (score_c !== 16'h0099) begin
      miscompares++;
      $display("FAIL wrap_pre got %h expected 0099", score_c);
    end
    tick();
    inc_c = 2'b00;
    vectors++;
    if ({score_c, ovf_c, go_c} !== {16'h0000, 2'b01, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_ovf got score=%h ovf=%b go=%b expected 0000 01 0", score_c, ovf_c, go_c);
    end
    inc_c = 2'b01; tick();
    inc_c = 2'b00;
    vectors++;
    if ({score_c, ovf_c} !== {16'h0001, 2'b00}) begin
      miscompares++;
      $display("FAIL wrap_after got score=%h ovf=%b expected 0001 00", score_c, ovf_c);
    end
  endtask

  task automatic test_tie();
    inc_a = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if ({score_a, go_a} !== {16'h1010, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_pre got score=%h go=%b expected 1010 0", score_a, go_a);
    end
    tick();
    inc_a = 2'b00;
    vectors++;
    if ({score_a, go_a, wid_a} !== {16'h1111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_win got score=%h go=%b wid=%0d expected 1111 1 0", score_a, go_a, wid_a);
    end
  endtask

  task automatic test_clr_over();
    clr_a = 1; inc_a = 2'b01; tick();
    clr_a = 0; inc_a = 2'b00;
    vectors++;
    if ({score_a, ovf_a, go_a, wid_a} !== 20'h0) begin
      miscompares++;
      $display("FAIL clr_over got score=%h ovf=%b go=%b wid=%0d expected all 0", score_a, ovf_a, go_a, wid_a);
    end
    inc_a = 2'b01; tick();
    inc_a = 2'b00;
    vectors++;
    if ({score_a, go_a} !== {16'h0001, 1'b0}) begin
      miscompares++;
      $display("FAIL clr_next_inc got score=%h go=%b expected 0001 0", score_a, go_a);
    end
  endtask

  task automatic test_big();
    inc_d = 4'b1000;
    for (int i = 0; i < 123; i++) tick();
    vectors++;
    if (score_d !== 48'h123_000_000_000) begin
      miscompares++;
      $display("FAIL big_mid got %h expected 123000000000", score_d);
    end
    rst_d = 1; tick(); rst_d = 0;
    vectors++;
    if ({score_d, go_d, wid_d} !== 51'h0) begin
      miscompares++;
      $display("FAIL big_reset got score=%h go=%b wid=%0d expected 0", score_d, go_d, wid_d);
    end
    for (int i = 0; i < 249; i++) tick();
    vectors++;
    if ({score_d, go_d} !== {48'h249_000_000_000, 1'b0}) begin
      miscompares++;
      $display("FAIL big_249 got score=%h go=%b expected 249000000000 0", score_d, go_d);
    end
    tick();
    vectors++;
    if ({score_d, go_d, wid_d} !== {48'h250_000_000_000, 1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL big_win got score=%h go=%b wid=%0d expected 250000000000 1 3", score_d, go_d, wid_d);
    end
    tick(); tick();
    inc_d = 4'b0000;
    vectors++;
    if ({score_d, ovf_d, go_d} !== {48'h250_000_000_000, 4'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL big_hold got score=%h ovf=%b go=%b expected 250000000000 0000 1", score_d, ovf_d, go_d);
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_carry();
    test_saturate();
    test_wrap();
    test_tie();
    test_clr_over();
    test_big();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
